booth_pp_accumulator: RTL

- Consumer side of the radix-4 Booth action-code interface. Accepts one 3-bit action code per digit, least-significant digit first.
- Forms each signed partial product of a latched multiplicand, then shifts and accumulates them into a 2N-bit signed product.
- Sits between the Booth encoder array and the FMAC adder stage.
- Sequential: one digit per accepted handshake; the product is presented with a valid/ready handshake.

---
 rtl/booth_pp_accumulator.sv | 132 +++++++++++++
 1 files changed

// File: rtl/booth_pp_accumulator.sv
// booth_pp_accumulator: consumer side of the radix-4 Booth action-code interface.
// Accepts one 3-bit action code per digit (LSD first), forms k*M as a 2N-bit
// signed partial product, shifts it by 2*digit and accumulates. The finished
// product is offered with a valid/ready handshake.
//
// Optional feature macro: BOOTH_ILLEGAL_CHK_EN
//   defined   -> accepted codes 5..7 contribute 0 and set sticky err
//   undefined -> codes 5..7 contribute 0, err tied to 0
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high; valid never depends on ready, and a producer holding valid keeps
// its data stable until the transfer edge.
module booth_pp_accumulator #(
  parameter int N  = 8,
  parameter int CW = ((N / 2) > 1) ? $clog2(N / 2) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [N-1:0]        multiplicand,
  input  logic                action_valid,
  input  logic [2:0]          action,
  output logic                action_ready,
  output logic [2*N-1:0]      product,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                busy,
  output logic                err,
  output logic [1:0]          fsm_state
);

  localparam int D = N / 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [N-1:0]     m_q;
  logic [2*N-1:0]   acc;
  logic [CW-1:0]    cnt;
  logic [2*N-1:0]   m_ext;
  logic [2*N-1:0]   pp;
  logic [2*N-1:0]   sum;
  logic             accept;
  logic             last;

  assign accept    = action_valid && (state == ACCUM);
  assign last      = (cnt == CW'(D - 1));
  assign fsm_state = state;

  // Partial product k*M in 2N bits; negation happens after sign extension so
  // that M = -2^(N-1) negates exactly.
  always_comb begin
    m_ext = {{N{m_q[N-1]}}, m_q};
    pp    = '0;
    case (action)
      3'd1:    pp = m_ext;
      3'd2:    pp = m_ext << 1;
      3'd3:    pp = -m_ext;
      3'd4:    pp = -(m_ext << 1);
      default: pp = '0;
    endcase
    sum = acc + (pp << {cnt, 1'b0});
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic and handshake outputs.
  always_comb begin
    state_nxt    = state;
    action_ready = 1'b0;
    out_valid    = 1'b0;
    busy         = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nxt = ACCUM;
      end
      ACCUM: begin
        action_ready = 1'b1;
        busy         = 1'b1;
        if (accept && last) state_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        busy      = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: latch M on start, accumulate accepted digits, publish the product.
  always_ff @(posedge clk) begin
    if (rst) begin
      m_q     <= '0;
      acc     <= '0;
      cnt     <= '0;
      product <= '0;
    end else if (state == IDLE && start) begin
      m_q <= multiplicand;
      acc <= '0;
      cnt <= '0;
    end else if (accept) begin
      acc <= sum;
      if (last) product <= sum;
      else      cnt     <= cnt + 1'b1;
    end
  end

`ifdef BOOTH_ILLEGAL_CHK_EN
  logic illegal;
  assign illegal = (action > 3'd4);

  // Sticky illegal-code flag, cleared by reset or an accepted start.
  always_ff @(posedge clk) begin
    if (rst)                          err <= 1'b0;
    else if (state == IDLE && start)  err <= 1'b0;
    else if (accept && illegal)       err <= 1'b1;
  end
`else
  assign err = 1'b0;
`endif

endmodule
